// File: rtl/if_stage.sv
// if_stage: RV32 instruction-fetch stage and IF/ID pipeline register.
// Latency: one instruction per cycle with zero-latency memory; the IF/ID register
//   loads on the edge that accepts the memory response.
// Backpressure: pc_write/if_id_write stall the PC and IF/ID. A response that arrives
//   while stalled is parked in a one-entry hold buffer. A redirect that hits with a
//   request outstanding waits in DRAIN for that stale response.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   pc_write, if_id_write       stall controls from hazard detection
//   branch_taken, branch_target EX-stage redirect (target bits [1:0] are ignored)
//   imem_req, imem_addr         fetch request; the address is held until imem_valid
//   imem_rdata, imem_valid      fetch response
//   if_id_pc/instr/valid        IF/ID register outputs
//   fetch_busy                  request outstanding without a response
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        advance;

  // The low target bits are architecturally zero for RV32 without compressed instructions.
  logic unused_target_bits;
  assign unused_target_bits = &{1'b0, branch_target[1:0]};

  assign advance = pc_write & if_id_write;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          if (advance) begin
            if_id_pc_d    = req_addr_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
          end else begin
            // The memory cannot be told to wait, so park the word until the stall clears.
            hold_d     = imem_rdata;
            hold_vld_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (if_id_write) begin
          if_id_pc_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (advance) begin
          if_id_pc_d    = req_addr_q;
          if_id_instr_d = hold_q;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          hold_vld_d    = 1'b0;
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        // The stale response is dropped; the PC already holds the redirect target.
        if (if_id_write) begin
          if_id_pc_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // A redirect overrides stalls and advances in every state.
    if (branch_taken) begin
      pc_d          = {branch_target[31:2], 2'b00};
      if_id_pc_d    = 32'd0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      hold_vld_d    = 1'b0;
      if ((state_q == HOLD) || ((state_q == FETCH) && imem_valid)) begin
        state_d = FETCH;
      end else begin
        state_d = DRAIN;
      end
    end

    // A new request always starts at the current PC; while draining, the old address
    // stays on the bus until the stale response arrives.
    req_addr_d = (state_d == FETCH) ? pc_d : req_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      hold_q        <= 32'd0;
      hold_vld_q    <= 1'b0;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req    = rst_n & ((state_q == FETCH) || (state_q == DRAIN));
  assign imem_addr   = req_addr_q;
  assign fetch_busy  = imem_req & ~imem_valid;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Memory returns address + 0x1000 as the instruction word.
  assign imem_rdata = imem_addr + 32'h0000_1000;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_busy   (fetch_busy)
  );

  // Advance one clock; inputs are changed #1 after the edge, outputs sampled #2 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    branch_taken = 1'b0; branch_target = 32'd0; imem_valid = 1'b1;
    tick(); tick();
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req_forced got=%0b exp=0", imem_req); else passed++;
    total++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy_forced got=%0b exp=0", fetch_busy); else passed++;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'd0)
      $display("FAIL reset_if_id got=%h/%h/%0b exp=0/13/0", if_id_pc, if_id_instr, if_id_valid); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL reset_first_req got=%0b/%h exp=1/0", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_stream();
    tick(); #1;
    total++; if (if_id_pc !== 32'd0 || if_id_instr !== 32'h1000 || if_id_valid !== 1'b1 || imem_addr !== 32'd4)
      $display("FAIL stream_0 got=%h/%h/%0b addr=%h exp=0/1000/1 addr=4", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'd4 || if_id_instr !== 32'h1004 || if_id_valid !== 1'b1 || imem_addr !== 32'd8)
      $display("FAIL stream_1 got=%h/%h/%0b addr=%h exp=4/1004/1 addr=8", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  task automatic test_stall_hold();
    pc_write = 1'b0; if_id_write = 1'b0;
    tick();
    pc_write = 1'b1; if_id_write = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || if_id_pc !== 32'd4 || if_id_instr !== 32'h1004 || if_id_valid !== 1'b1)
      $display("FAIL stall_hold got req=%0b %h/%h/%0b exp req=0 4/1004/1", imem_req, if_id_pc, if_id_instr, if_id_valid); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'd8 || if_id_instr !== 32'h1008 || if_id_valid !== 1'b1 || imem_addr !== 32'hC || imem_req !== 1'b1)
      $display("FAIL stall_release got=%h/%h/%0b addr=%h req=%0b exp=8/1008/1 addr=c req=1", if_id_pc, if_id_instr, if_id_valid, imem_addr, imem_req); else passed++;
  endtask

  task automatic test_slow_mem();
    imem_valid = 1'b0;
    #1;
    total++; if (fetch_busy !== 1'b1) $display("FAIL slow_busy0 got=%0b exp=1", fetch_busy); else passed++;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'd0 || imem_addr !== 32'hC || fetch_busy !== 1'b1)
        $display("FAIL slow_bubble%0d got=%h/%h/%0b addr=%h busy=%0b exp=0/13/0 addr=c busy=1", i, if_id_pc, if_id_instr, if_id_valid, imem_addr, fetch_busy); else passed++;
    end
    imem_valid = 1'b1;
    #1;
    total++; if (fetch_busy !== 1'b0) $display("FAIL slow_busy_clear got=%0b exp=0", fetch_busy); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'hC || if_id_instr !== 32'h100C || if_id_valid !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL slow_load got=%h/%h/%0b addr=%h exp=c/100c/1 addr=10", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  task automatic test_branch_valid();
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || imem_addr !== 32'h100 || imem_req !== 1'b1)
      $display("FAIL branch_flush got=%h/%0b addr=%h req=%0b exp=13/0 addr=100 req=1", if_id_instr, if_id_valid, imem_addr, imem_req); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'h100 || if_id_instr !== 32'h1100 || if_id_valid !== 1'b1 || imem_addr !== 32'h104)
      $display("FAIL branch_target_fetch got=%h/%h/%0b addr=%h exp=100/1100/1 addr=104", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  task automatic test_branch_drain();
    imem_valid = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || if_id_valid !== 1'b0)
      $display("FAIL drain_enter got req=%0b addr=%h v=%0b exp req=1 addr=104 v=0", imem_req, imem_addr, if_id_valid); else passed++;
    tick(); #1;
    total++; if (imem_addr !== 32'h104 || if_id_valid !== 1'b0 || fetch_busy !== 1'b1)
      $display("FAIL drain_wait got addr=%h v=%0b busy=%0b exp addr=104 v=0 busy=1", imem_addr, if_id_valid, fetch_busy); else passed++;
    imem_valid = 1'b1;
    tick(); #1;
    total++; if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL drain_drop got addr=%h v=%0b req=%0b exp addr=200 v=0 req=1", imem_addr, if_id_valid, imem_req); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'h200 || if_id_instr !== 32'h1200 || if_id_valid !== 1'b1 || imem_addr !== 32'h204)
      $display("FAIL drain_resume got=%h/%h/%0b addr=%h exp=200/1200/1 addr=204", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  task automatic test_reset_in_hold();
    pc_write = 1'b0; if_id_write = 1'b0;
    tick();
    #1;
    total++; if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h200)
      $display("FAIL hold_before_reset got req=%0b v=%0b pc=%h exp req=0 v=1 pc=200", imem_req, if_id_valid, if_id_pc); else passed++;
    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL reset_from_hold got v=%0b req=%0b addr=%h exp v=0 req=1 addr=0", if_id_valid, imem_req, imem_addr); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'd0 || if_id_instr !== 32'h1000 || if_id_valid !== 1'b1 || imem_addr !== 32'd4)
      $display("FAIL reset_hold_empty got=%h/%h/%0b addr=%h exp=0/1000/1 addr=4", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  task automatic test_reset_beats_branch();
    rst_n = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    rst_n = 1'b1; branch_taken = 1'b0;
    #1;
    total++; if (imem_addr !== 32'd0 || imem_req !== 1'b1 || if_id_valid !== 1'b0)
      $display("FAIL reset_over_branch got addr=%h req=%0b v=%0b exp addr=0 req=1 v=0", imem_addr, imem_req, if_id_valid); else passed++;
  endtask

  task automatic test_pc_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got=%h exp=fffffffc", imem_addr); else passed++;
    tick(); #1;
    total++; if (if_id_pc !== 32'hFFFF_FFFC || if_id_instr !== 32'h0000_0FFC || if_id_valid !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL wrap_next got=%h/%h/%0b addr=%h exp=fffffffc/ffc/1 addr=0", if_id_pc, if_id_instr, if_id_valid, imem_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_slow_mem();
    test_branch_valid();
    test_branch_drain();
    test_reset_in_hold();
    test_reset_beats_branch();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32 pipeline.
It is the direct consumer of the hazard detection unit's PCWrite and IF/ID-write outputs, and it takes branch redirects from EX.
It owns the PC, the instruction-memory request handshake, a one-entry hold buffer for instructions that return while stalled, and the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID for bubbles and flushes.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
pc_write  input  1  from hazard detection; 1 = PC may advance.
if_id_write  input  1  from hazard detection; 1 = IF/ID may load.
branch_taken  input  1  EX-stage redirect request.
branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; stable while imem_req=1 until imem_valid.
imem_rdata  input  32  instruction data; qualified by imem_valid.
imem_valid  input  1  response for the current request; may arrive in the same cycle as the request or N cycles later.
if_id_pc  output  32  IF/ID registered PC.
if_id_instr  output  32  IF/ID registered instruction.
if_id_valid  output  1  IF/ID contains a real instruction.
fetch_busy  output  1  1 while a request is outstanding without a response.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC, state=FETCH.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - Hold buffer is empty.
  - imem_req and fetch_busy are forced to 0 combinationally while rst_n=0.
  - Any in-flight response is ignored.
- advance = pc_write & if_id_write. Any other combination is a stall: PC holds and IF/ID holds.
- Address register: req_addr is loaded from pc when entering FETCH. imem_addr = req_addr.
- States:
  - FETCH: imem_req=1.
    - imem_valid & advance: IF/ID <= {req_addr, imem_rdata, valid=1}; pc <= pc+4; stay in FETCH. Next imem_addr is pc+4, so there is 1 instruction per cycle with zero-latency memory.
    - imem_valid & stall: imem_rdata goes into the hold buffer; go to HOLD; IF/ID unchanged.
    - !imem_valid: fetch_busy=1. If if_id_write=1, load a bubble into IF/ID (valid=0, instr=NOP_INSTR, pc=0); otherwise IF/ID holds. PC holds.
  - HOLD: imem_req=0. On advance, IF/ID <= {req_addr, hold buffer, valid=1}; pc <= pc+4; go to FETCH.
  - DRAIN: imem_req=1 with the old req_addr. The response is discarded. On imem_valid, go to FETCH at the already-redirected pc. While in DRAIN, if_id_write=1 loads bubbles.
- branch_taken has the highest priority over stall and advance in every state:
  - pc <= {branch_target[31:2],2'b00}.
  - IF/ID is flushed to a bubble, even when if_id_write=0.
  - The hold buffer is cleared.
  - Next state: FETCH if no request is outstanding (state HOLD, or FETCH with imem_valid=1 this cycle); DRAIN if FETCH with imem_valid=0 or already DRAIN.
- branch_taken in the same cycle as a stall: the flush wins and the pipeline resumes at the target.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
- Synchronous reset overrides everything, including branch_taken, in the same cycle.

Test Plan:
1. Reset with RESET_PC=0, imem_valid tied high, instr = address+0x1000: imem_addr is 0,4,8,… on consecutive cycles. IF/ID shows (0,0x1000,v=1), then (4,0x1004,v=1). if_id_valid=0 in the first cycle after reset.
2. Load-use stall: pc_write=if_id_write=0 for 1 cycle while fetching pc=8. IF/ID holds (4,0x1004). State goes to HOLD with imem_req=0. Next cycle IF/ID=(8,0x1008) and imem_addr=0xC. No instruction is lost or duplicated.
3. imem_valid delayed 2 cycles: fetch_busy=1 for 2 cycles and IF/ID gets 2 bubbles (v=0, instr=0x13). Then (addr,data,v=1) loads.
4. branch_taken with branch_target=0x103 while in FETCH and imem_valid=1: IF/ID is flushed (v=0, 0x13). Next imem_addr=0x100; the returned response is not written.
5. branch_taken to 0x200 with a request outstanding: state DRAIN holds the old imem_addr until imem_valid; that data is dropped. Then imem_addr=0x200. No valid IF/ID entry appears in between.
6. rst_n=0 for 1 cycle while in HOLD with IF/ID valid: next cycle pc=RESET_PC, if_id_valid=0, hold buffer empty, imem_req=1 at RESET_PC. PC wrap check: branch to 0xFFFF_FFFC, then the next fetch is at 0x0.
